// File: rtl/irq_pend_latch8_pkg.sv
// ============================================================================
//  irq_pkg : shared widths and helpers for the irq_pend_latch8 request front end
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [N_REQ-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_pend_latch8_bit_sync.sv
// ============================================================================
//  bit_sync : multi-flop synchroniser for one asynchronous line, reset clears all stages
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module bit_sync #(
  parameter int STAGES = 2  // legal 2..3
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/irq_pend_latch8.sv
// ============================================================================
//  irq_pend_latch8 : synchronises 8 request lines into sticky pending bits feeding
//                    the 8->3 priority encoder; ack clears, lost requests are counted
//  Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module irq_pend_latch8
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  input  logic [ID_W-1:0]  ack_id,
  output logic [N_REQ-1:0] pend_out,
  output logic [N_REQ-1:0] pending,
  output logic             any_pend,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_REQ-1:0] w_sync;
  logic [N_REQ-1:0] w_ev;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_drop;
  logic [CNT_W:0]   w_sum;

  logic [N_REQ-1:0] prev_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sync
    bit_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (req_in[i]),
      .sync_o  (w_sync[i])
    );
  end

  always_comb begin
    w_ev   = EDGE_MODE ? (w_sync & ~prev_q) : w_sync;
    w_clr  = ack ? onehot(ack_id) : '0;
    // a fresh event beats a same-cycle ack, so the request is kept, not lost
    pending_d = (pending_q & ~w_clr) | w_ev;
    w_drop    = w_ev & pending_q & ~w_clr;
    w_sum     = {1'b0, drop_cnt_q} + (CNT_W+1)'(popcount(w_drop));
    drop_cnt_d = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= w_sync;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_out = pending_q & mask;
  assign any_pend = |pend_out;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_pend_latch8.sv
// ============================================================================
//  tb_irq_pend_latch8 : vector table + scoreboard bench for edge and level builds
//  Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_irq_pend_latch8;
  import irq_pkg::*;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] out;
    logic [7:0] drop;
  } vec_t;

  typedef struct {
    int         which;
    logic [7:0] pend;
    logic [7:0] out;
    logic [7:0] drop;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1, rst0 = 1'b1;
  logic [7:0] req_in = 8'h00, req0 = 8'h00;
  logic [7:0] mask = 8'hFF, mask0 = 8'hFF;
  logic       ack = 1'b0, ack0 = 1'b0;
  logic [2:0] ack_id = 3'd0, ack_id0 = 3'd0;
  logic [7:0] pend_out, pending, drop_cnt;
  logic [7:0] pend_out0, pending0, drop_cnt0;
  logic       any_pend, any_pend0;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  irq_pend_latch8 #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .ack(ack), .ack_id(ack_id),
    .pend_out(pend_out), .pending(pending), .any_pend(any_pend), .drop_cnt(drop_cnt)
  );

  irq_pend_latch8 #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst0), .req_in(req0), .mask(mask0), .ack(ack0), .ack_id(ack_id0),
    .pend_out(pend_out0), .pending(pending0), .any_pend(any_pend0), .drop_cnt(drop_cnt0)
  );

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] m,
                              input logic a, input logic [2:0] id, input logic [7:0] p,
                              input logic [7:0] o, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req = rq; v.mask = m; v.ack = a; v.id = id;
    v.pend = p; v.out = o; v.drop = d;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    logic [7:0] gp, go, gd;
    logic       ga;
    e = sb_q.pop_front();
    if (e.which == 0) begin
      gp = pending;  go = pend_out;  ga = any_pend;  gd = drop_cnt;
    end else begin
      gp = pending0; go = pend_out0; ga = any_pend0; gd = drop_cnt0;
    end
    cmp({e.nm, ".pending"},  gp, e.pend);
    cmp({e.nm, ".pend_out"}, go, e.out);
    cmp({e.nm, ".any_pend"}, {7'd0, ga}, {7'd0, (e.out != 8'h00)});
    cmp({e.nm, ".drop_cnt"}, gd, e.drop);
  endtask

  task automatic step(input int which, input vec_t v, input bit chk, input string nm);
    if (which == 0) begin
      rst = v.rst; req_in = v.req; mask = v.mask; ack = v.ack; ack_id = v.id;
    end else begin
      rst0 = v.rst; req0 = v.req; mask0 = v.mask; ack0 = v.ack; ack_id0 = v.id;
    end
    if (chk) sb_q.push_back('{which, v.pend, v.out, v.drop, nm});
    @(posedge clk);
    #1;
    if (chk) sb_check();
  endtask

  // n bit-3 pulses, then enough idle cycles for the last edge to land
  task automatic pulses(input int n, input logic [7:0] exp_drop, input string nm);
    for (int i = 0; i < n; i++) begin
      step(0, mk(1'b0, 8'h08, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00), 1'b0, "");
      step(0, mk(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00), 1'b0, "");
    end
    step(0, mk(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00), 1'b0, "");
    step(0, mk(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00), 1'b0, "");
    step(0, mk(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h08, 8'h08, exp_drop), 1'b1, nm);
  endtask

  initial begin
    // reset with all lines high, then a single synchronised capture
    tbl.push_back(mk(1, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 8'hFF, 8'hFF, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 8'hFF, 8'hFF, 0));
    // back-to-back acks, one bit per cycle
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 0, 8'hFE, 8'hFE, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 1, 8'hFC, 8'hFC, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 2, 8'hF8, 8'hF8, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 3, 8'hF0, 8'hF0, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 4, 8'hE0, 8'hE0, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 5, 8'hC0, 8'hC0, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 6, 8'h80, 8'h80, 0));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 7, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 3, 8'h00, 8'h00, 0));
    // single pulse on bit 4, then ack
    tbl.push_back(mk(0, 8'h10, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 4, 8'h00, 8'h00, 0));
    // second bit-4 edge while still pending is dropped
    tbl.push_back(mk(0, 8'h10, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 8'h10, 8'hFF, 0, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 1));
    // bit-6 event landing together with ack on bit 6
    tbl.push_back(mk(0, 8'h40, 8'hFF, 0, 0, 8'h10, 8'h10, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h10, 8'h10, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h50, 8'h50, 1));
    tbl.push_back(mk(0, 8'h40, 8'hFF, 0, 0, 8'h50, 8'h50, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h50, 8'h50, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 6, 8'h50, 8'h50, 1));
    // build pending = 48, then exercise the mask
    tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 4, 8'h40, 8'h40, 1));
    tbl.push_back(mk(0, 8'h08, 8'hFF, 0, 0, 8'h40, 8'h40, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h40, 8'h40, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h48, 8'h48, 1));
    tbl.push_back(mk(0, 8'h00, 8'hBF, 0, 0, 8'h48, 8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h48, 8'h48, 1));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h48, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h48, 8'h48, 1));
    // mid-operation reset discards an in-flight bit-1 event
    tbl.push_back(mk(0, 8'h02, 8'hFF, 0, 0, 8'h48, 8'h48, 1));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i], 1'b1, $sformatf("row%0d", i));
    end

    // drop counter: count up, approach and hit saturation, stay there
    pulses(1,   8'd0,   "sat_first");
    pulses(9,   8'd9,   "sat_9");
    pulses(245, 8'd254, "sat_254");
    pulses(1,   8'd255, "sat_255");
    pulses(46,  8'd255, "sat_hold");

    // mask change reflected before any clock edge
    mask = 8'hF7;
    sb_q.push_back('{0, 8'h08, 8'h00, 8'hFF, "mask_same_cycle_off"});
    #1;
    sb_check();
    mask = 8'hFF;
    sb_q.push_back('{0, 8'h08, 8'h08, 8'hFF, "mask_same_cycle_on"});
    #1;
    sb_check();

    // level-capture build: held line sets once, then drops every cycle
    step(1, mk(1, 8'h04, 8'hFF, 0, 0, 8'h00, 8'h00, 0), 1'b1, "lvl_rst");
    for (int k = 1; k <= 13; k++) begin
      logic [7:0] ep, ed;
      ep = (k >= 3) ? 8'h04 : 8'h00;
      ed = (k >= 4) ? 8'((k > 12 ? 12 : k) - 3) : 8'd0;
      step(1, mk(0, (k <= 10) ? 8'h04 : 8'h00, 8'hFF, 0, 0, ep, ep, ed), 1'b1,
           $sformatf("lvl%0d", k));
    end
    step(1, mk(0, 8'h00, 8'hFF, 1, 2, 8'h00, 8'h00, 8'd9), 1'b1, "lvl_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
